seg_scan_capture: RTL and testbench

//  Receive side of the multiplexed 7-segment display bus driven by the realtimeclock core.

---
 rtl/seg_scan_capture.sv | 239 +++++++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a scanned 7-segment bus and decodes each frame.
// Complete frames are published to a host over an Avalon-MM slave.
module seg_scan_capture #(
  parameter int NUM_DIGITS     = 6,
  parameter int SETTLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            seg_in,
  input  logic [NUM_DIGITS-1:0] sel_in,
  input  logic [2:0]            avs_address,
  input  logic                  avs_read,
  output logic [31:0]           avs_readdata,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  output logic                  irq
);

  localparam int N  = NUM_DIGITS;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, SETTLE, CAPTURE, HOLD
  } state_t;

  state_t state, nxt;

  logic [7:0]     seg_s1, seg_s2, seg_n, lat_seg;
  logic [N-1:0]   sel_s1, sel_s2, sel_n, lat_sel;
  logic [CW-1:0]  cnt;
  logic           one_hot, load, inc, cap;
  logic [N-1:0]   mask;
  logic           complete;
  logic [4*N-1:0] sh_dig, digits;
  logic [N-1:0]   sh_dp, sh_inv, dp, inv;
  logic           frame_valid, irq_en, enable;
  logic [15:0]    frame_count;
  logic [4:0]     dec;
  logic [31:0]    rd;
  logic           unused_ok;

  assign unused_ok = ^avs_writedata[31:2];

  // Returns {invalid, nibble} for a segment pattern a..g.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h10;
    unique case (p)
      7'h3F: r = 5'h00;
      7'h06: r = 5'h01;
      7'h5B: r = 5'h02;
      7'h4F: r = 5'h03;
      7'h66: r = 5'h04;
      7'h6D: r = 5'h05;
      7'h7D: r = 5'h06;
      7'h07: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h6F: r = 5'h09;
      7'h77: r = 5'h0A;
      7'h7C: r = 5'h0B;
      7'h39: r = 5'h0C;
      7'h5E: r = 5'h0D;
      7'h79: r = 5'h0E;
      7'h71: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  // Two-stage synchronizer on the asynchronous display lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      sel_s1 <= '0;
      sel_s2 <= '0;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      sel_s1 <= sel_in;
      sel_s2 <= sel_s1;
    end
  end

  assign seg_n   = SEG_ACTIVE_LOW ? ~seg_s2 : seg_s2;
  assign sel_n   = SEL_ACTIVE_LOW ? ~sel_s2 : sel_s2;
  assign one_hot = (sel_n != '0) &&
                   ((sel_n & (sel_n - N'(1))) == '0);
  assign dec      = decode(lat_seg[6:0]);
  assign complete = (mask == '1);

  // Scan FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  // Next state: settle on a stable one-hot digit, capture once, then hold.
  always_comb begin
    nxt  = state;
    load = 1'b0;
    inc  = 1'b0;
    cap  = 1'b0;
    if (!enable) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (one_hot) begin
            nxt  = SETTLE;
            load = 1'b1;
          end
        end
        SETTLE: begin
          if (seg_n == lat_seg && sel_n == lat_sel) begin
            if (cnt >= LAST) nxt = CAPTURE;
            else             inc = 1'b1;
          end else if (one_hot) begin
            load = 1'b1;
          end else begin
            nxt = IDLE;
          end
        end
        CAPTURE: begin
          cap = 1'b1;
          nxt = HOLD;
        end
        HOLD: begin
          if (sel_n != lat_sel) begin
            if (one_hot) begin
              nxt  = SETTLE;
              load = 1'b1;
            end else begin
              nxt = IDLE;
            end
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // Stability counter and latched digit value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      lat_seg <= '0;
      lat_sel <= '0;
    end else if (load) begin
      cnt     <= CW'(1);
      lat_seg <= seg_n;
      lat_sel <= sel_n;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Shadow frame and capture mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask   <= '0;
      sh_dig <= '0;
      sh_dp  <= '0;
      sh_inv <= '0;
    end else begin
      if (!enable || complete) mask <= '0;
      else if (cap)            mask <= mask | lat_sel;
      if (cap) begin
        for (int i = 0; i < N; i++) begin
          if (lat_sel[i]) begin
            sh_dig[4*i +: 4] <= dec[3:0];
            sh_dp[i]         <= lat_seg[7];
            sh_inv[i]        <= dec[4];
          end
        end
      end
    end
  end

  // Published frame, status and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits      <= '0;
      dp          <= '0;
      inv         <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      irq_en      <= 1'b0;
      enable      <= 1'b0;
    end else begin
      if (complete) begin
        digits <= sh_dig;
        dp     <= sh_dp;
        inv    <= sh_inv;
      end
      if (complete)
        frame_valid <= 1'b1;
      else if (avs_write && avs_address == 3'd2 && avs_writedata[0])
        frame_valid <= 1'b0;
      if (avs_write && avs_address == 3'd3)
        frame_count <= '0;
      else if (complete)
        frame_count <= frame_count + 16'd1;
      if (avs_write && avs_address == 3'd4) begin
        irq_en <= avs_writedata[0];
        enable <= avs_writedata[1];
      end
    end
  end

  // Read mux.
  always_comb begin
    rd = '0;
    unique case (avs_address)
      3'd0: rd[4*N-1:0] = digits;
      3'd1: begin
        rd[N-1:0] = dp;
        rd[8 +: N] = inv;
      end
      3'd2: rd[1:0]  = {(mask != '0), frame_valid};
      3'd3: rd[15:0] = frame_count;
      3'd4: rd[1:0]  = {enable, irq_en};
      default: rd = '0;
    endcase
  end

  // Registered read data, one cycle after the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd;
    else               avs_readdata <= '0;
  end

  assign irq = frame_valid & irq_en;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed, table-driven bench for seg_scan_capture.
// Frames are scanned active-low; registers are read back over Avalon-MM.
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  seg_in;
  logic [5:0]  sel_in;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  seg_scan_capture dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .seg_in        (seg_in),
    .sel_in        (sel_in),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  logic [7:0] P [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  typedef struct {
    logic [47:0] pats;
    logic [31:0] digits;
    logic [31:0] flags;
    logic [31:0] count;
  } frame_t;

  frame_t frames [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    d           = avs_readdata;
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(nm, d, exp);
  endtask

  task automatic scan(input logic [47:0] pats, input int ndig);
    for (int i = 0; i < ndig; i++) begin
      @(negedge clk);
      sel_in = ~(6'b1 << i);
      seg_in = ~pats[8*i +: 8];
      repeat (9) @(negedge clk);
    end
    sel_in = '1;
    seg_in = '1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    frames[0] = '{{P[1], P[2], P[3], P[4], P[5], P[6]},
                  32'h0012_3456, 32'h0, 32'd1};
    frames[1] = '{{P[12], P[11], P[10], P[9], P[8], P[7]},
                  32'h00CB_A987, 32'h0, 32'd2};
    frames[2] = '{{P[2], P[1], P[0], P[15], P[14], P[13]},
                  32'h0021_0FED, 32'h0, 32'd3};
    frames[3] = '{{P[5], P[4], P[3], 8'hC9, P[1], P[0]},
                  32'h0054_3010, 32'h404, 32'd4};

    reset_n       = 1'b0;
    seg_in        = '1;
    sel_in        = '1;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    chk("reset_irq", {31'b0, irq}, 32'h0);
    // Lines toggle while capture is disabled: nothing may be recorded.
    scan(frames[0].pats, 6);
    for (int a = 0; a < 8; a++) rd_chk($sformatf("reset_rd%0d", a), 3'(a), 32'h0);
    chk("disabled_irq", {31'b0, irq}, 32'h0);

    bus_wr(3'd4, 32'h3);
    rd_chk("ctrl", 3'd4, 32'h3);

    for (int f = 0; f < 4; f++) begin
      scan(frames[f].pats, 6);
      rd_chk($sformatf("f%0d_digits", f), 3'd0, frames[f].digits);
      rd_chk($sformatf("f%0d_flags", f), 3'd1, frames[f].flags);
      rd_chk($sformatf("f%0d_status", f), 3'd2, 32'h1);
      rd_chk($sformatf("f%0d_count", f), 3'd3, frames[f].count);
      chk($sformatf("f%0d_irq", f), {31'b0, irq}, 32'h1);
      if (f == 0) begin
        bus_wr(3'd2, 32'h1);
        chk("w1c_irq", {31'b0, irq}, 32'h0);
        rd_chk("w1c_status", 3'd2, 32'h0);
        // Held one cycle short of the settle time.
        @(negedge clk);
        sel_in = 6'b111110;
        seg_in = ~P[8];
        repeat (3) @(negedge clk);
        sel_in = '1;
        seg_in = '1;
        repeat (20) @(negedge clk);
        rd_chk("short_status", 3'd2, 32'h0);
        // Two selects active, then none.
        sel_in = 6'b111010;
        seg_in = ~P[8];
        repeat (20) @(negedge clk);
        sel_in = '1;
        repeat (20) @(negedge clk);
        rd_chk("multi_status", 3'd2, 32'h0);
        rd_chk("multi_count", 3'd3, 32'd1);
      end
    end

    bus_wr(3'd0, 32'hFFFF_FFFF);
    rd_chk("ro_digits", 3'd0, 32'h0054_3010);
    bus_wr(3'd3, 32'hDEAD);
    rd_chk("count_clr", 3'd3, 32'h0);

    // Partial frame then reset: nothing of it may survive.
    bus_wr(3'd2, 32'h1);
    scan(frames[0].pats, 3);
    rd_chk("partial_status", 3'd2, 32'h2);
    do_reset();
    rd_chk("rst_status", 3'd2, 32'h0);
    rd_chk("rst_ctrl", 3'd4, 32'h0);
    rd_chk("rst_digits", 3'd0, 32'h0);
    bus_wr(3'd4, 32'h3);
    // Digit 0 first shows A, then is overwritten by the full scan.
    scan({40'h0, P[10]}, 1);
    rd_chk("one_status", 3'd2, 32'h2);
    scan(frames[0].pats, 6);
    rd_chk("post_count", 3'd3, 32'd1);
    rd_chk("post_digits", 3'd0, 32'h0012_3456);
    rd_chk("post_status", 3'd2, 32'h1);
    chk("post_irq", {31'b0, irq}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
